// File: rtl/mul_add_pipe.sv
// Pipelined saturating fixed-point multiply / multiply-accumulate unit, LAT cycles issue to done.
// Define MUL_ADD_PIPE_ROUND_EN for round-half-up product scaling; otherwise the product is truncated.
module mul_add_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 22,
  parameter int LAT   = 3,
  parameter int GUARD = 8
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             clk_en,
  input  logic             start,
  input  logic [1:0]       n,
  input  logic [WIDTH-1:0] dataa,
  input  logic [WIDTH-1:0] datab,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int AW = WIDTH + GUARD;
  // Internal sum width: wide enough for the scaled product and for acc plus product without overflow.
  localparam int SW = ((2 * WIDTH + 2) > (AW + 2)) ? (2 * WIDTH + 2) : (AW + 2);
  localparam int D  = LAT - 1;

  localparam logic signed [SW-1:0] W_MAX_S = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] W_MIN_S = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] A_MAX_S = {{(SW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [SW-1:0] A_MIN_S = {{(SW-AW+1){1'b1}}, {(AW-1){1'b0}}};
  localparam logic signed [SW-1:0] RND_S   = {{(SW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_MUL  = 2'd0,
    OP_MAC  = 2'd1,
    OP_CLR  = 2'd2,
    OP_READ = 2'd3
  } op_e;

  function automatic logic [WIDTH-1:0] sat_w(input logic signed [SW-1:0] x);
    if (x > W_MAX_S) begin
      sat_w = W_MAX_S[WIDTH-1:0];
    end else if (x < W_MIN_S) begin
      sat_w = W_MIN_S[WIDTH-1:0];
    end else begin
      sat_w = x[WIDTH-1:0];
    end
  endfunction

  function automatic logic [AW-1:0] sat_a(input logic signed [SW-1:0] x);
    if (x > A_MAX_S) begin
      sat_a = A_MAX_S[AW-1:0];
    end else if (x < A_MIN_S) begin
      sat_a = A_MIN_S[AW-1:0];
    end else begin
      sat_a = x[AW-1:0];
    end
  endfunction

  logic signed [2*WIDTH-1:0] a_ext_s, b_ext_s, prod_s;
  logic signed [SW-1:0]      prod_ext_s, rnd_s, scaled_s;

  logic                 pipe_v_q  [D];
  logic                 pipe_v_d  [D];
  op_e                  pipe_op_q [D];
  op_e                  pipe_op_d [D];
  logic signed [SW-1:0] pipe_p_q  [D];
  logic signed [SW-1:0] pipe_p_d  [D];

  logic [AW-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 done_q, done_d;
  logic signed [SW-1:0] acc_ext_s, sum_s, mac_ext_s;
  logic [AW-1:0]        mac_acc_s;

  // Full-precision signed product scaled down by FRAC, rounded or truncated.
  always_comb begin
    a_ext_s    = {{WIDTH{dataa[WIDTH-1]}}, dataa};
    b_ext_s    = {{WIDTH{datab[WIDTH-1]}}, datab};
    prod_s     = a_ext_s * b_ext_s;
    prod_ext_s = {{(SW-2*WIDTH){prod_s[2*WIDTH-1]}}, prod_s};
`ifdef MUL_ADD_PIPE_ROUND_EN
    rnd_s      = prod_ext_s + RND_S;
`else
    rnd_s      = prod_ext_s;
`endif
    scaled_s   = rnd_s >>> FRAC;
  end

  // Next state of the op pipeline: stage 0 takes the new issue, later stages shift.
  always_comb begin
    for (int i = 0; i < D; i++) begin
      pipe_v_d[i]  = 1'b0;
      pipe_op_d[i] = OP_MUL;
      pipe_p_d[i]  = '0;
    end
    pipe_v_d[0]  = start;
    pipe_op_d[0] = op_e'(n);
    pipe_p_d[0]  = scaled_s;
    for (int i = 1; i < D; i++) begin
      pipe_v_d[i]  = pipe_v_q[i-1];
      pipe_op_d[i] = pipe_op_q[i-1];
      pipe_p_d[i]  = pipe_p_q[i-1];
    end
  end

  // Final stage: the only place the accumulator is read or written, so ops act in issue order.
  always_comb begin
    acc_ext_s = {{(SW-AW){acc_q[AW-1]}}, acc_q};
    sum_s     = acc_ext_s + pipe_p_q[D-1];
    mac_acc_s = sat_a(sum_s);
    mac_ext_s = {{(SW-AW){mac_acc_s[AW-1]}}, mac_acc_s};
    acc_d     = acc_q;
    result_d  = result_q;
    done_d    = 1'b0;
    if (pipe_v_q[D-1]) begin
      done_d = 1'b1;
      case (pipe_op_q[D-1])
        OP_MUL:  result_d = sat_w(pipe_p_q[D-1]);
        OP_MAC: begin
          acc_d    = mac_acc_s;
          result_d = sat_w(mac_ext_s);
        end
        OP_CLR: begin
          acc_d    = '0;
          result_d = '0;
        end
        OP_READ: result_d = sat_w(acc_ext_s);
        default: result_d = result_q;
      endcase
    end else begin
      done_d = 1'b0;
    end
  end

  // All state advances only on enabled edges; reset discards in-flight ops.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      for (int i = 0; i < D; i++) begin
        pipe_v_q[i]  <= 1'b0;
        pipe_op_q[i] <= OP_MUL;
        pipe_p_q[i]  <= '0;
      end
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      for (int i = 0; i < D; i++) begin
        pipe_v_q[i]  <= pipe_v_d[i];
        pipe_op_q[i] <= pipe_op_d[i];
        pipe_p_q[i]  <= pipe_p_d[i];
      end
      acc_q    <= acc_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_mul_add_pipe.sv
// Directed + scoreboard bench for mul_add_pipe at default parameters (Q10.22, LAT=3).
module tb_mul_add_pipe;

  localparam int W    = 32;
  localparam int FRAC = 22;
  localparam int LAT  = 3;

  localparam logic [1:0] MUL  = 2'd0;
  localparam logic [1:0] MAC  = 2'd1;
  localparam logic [1:0] CLR  = 2'd2;
  localparam logic [1:0] READ = 2'd3;

  logic         clk    = 1'b0;
  logic         aclr_n = 1'b0;
  logic         clk_en = 1'b0;
  logic         start  = 1'b0;
  logic [1:0]   n      = 2'd0;
  logic [W-1:0] dataa  = '0;
  logic [W-1:0] datab  = '0;
  logic [W-1:0] result;
  logic         done;

  mul_add_pipe #(.WIDTH(W), .FRAC(FRAC), .LAT(LAT), .GUARD(8)) dut (
    .clk(clk), .aclr_n(aclr_n), .clk_en(clk_en), .start(start), .n(n),
    .dataa(dataa), .datab(datab), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] val;
    int           edge_no;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks   = 0;
  int   errors   = 0;
  int   en_edges = 0;
  bit   last_upd = 1'b0;

  // Count the edges at which the DUT was allowed to update.
  always @(posedge clk) begin
    last_upd = clk_en && aclr_n;
    if (clk_en && aclr_n) en_edges++;
  end

  // Scoreboard: each fresh done pops one expectation and checks value and edge.
  always @(negedge clk) begin
    if (aclr_n && last_upd && done) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_done: observed done=1 result=%h, required no done", result);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (result === e.val) else begin
          errors++;
          $error("FAIL %s value: observed %h, required %h", e.tag, result, e.val);
        end
        checks++;
        assert (en_edges === e.edge_no) else begin
          errors++;
          $error("FAIL %s latency: observed done at edge %0d, required edge %0d", e.tag, en_edges, e.edge_no);
        end
      end
    end
  end

  function automatic logic [W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint p;
    logic [63:0] pv;
    p = longint'($signed(a)) * longint'($signed(b));
`ifdef MUL_ADD_PIPE_ROUND_EN
    p = p + 64'sd2097152;
`endif
    p = p >>> FRAC;
    if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
    pv = p;
    return pv[31:0];
  endfunction

  // Drive one op for one cycle (clk_en assumed high) and queue its expectation.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] val, input string tag);
    start = 1'b1;
    n     = op;
    dataa = a;
    datab = b;
    sb.push_back('{val, en_edges + LAT, tag});
    @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    start = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  logic [W-1:0] ra, rb, rnd_exp, rnd_neg_exp;

  initial begin
    #12;
    checks++;
    assert (result === 32'h0000_0000 && done === 1'b0) else begin
      errors++;
      $error("FAIL reset_state: observed result=%h done=%b, required 00000000/0", result, done);
    end
    @(negedge clk);
    aclr_n = 1'b1;
    clk_en = 1'b1;
    idle(2);

    issue(MUL, 32'h0060_0000, 32'h0080_0000, 32'h00C0_0000, "mul_1p5x2");
    issue(MUL, 32'hFFC0_0000, 32'h0060_0000, 32'hFFA0_0000, "mul_m1x1p5");
    issue(MUL, 32'h4000_0000, 32'h0080_0000, 32'h7FFF_FFFF, "sat_pos");
    issue(MUL, 32'hC000_0000, 32'h0080_0000, 32'h8000_0000, "sat_neg");
`ifdef MUL_ADD_PIPE_ROUND_EN
    rnd_exp = 32'h0000_0001;
    rnd_neg_exp = 32'h0000_0000;
`else
    rnd_exp = 32'h0000_0000;
    rnd_neg_exp = 32'hFFFF_FFFF;
`endif
    issue(MUL, 32'h0000_0001, 32'h0020_0000, rnd_exp, "round_pos");
    issue(MUL, 32'hFFFF_FFFF, 32'h0020_0000, rnd_neg_exp, "round_neg");
    idle(5);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
      issue(MUL, ra, rb, mul_model(ra, rb), "mul_rand");
    end
    idle(5);

    issue(CLR, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, "mac_clr");
    issue(MAC, 32'h0040_0000, 32'h0040_0000, 32'h0040_0000, "mac_1");
    issue(MAC, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000, "mac_2");
    issue(MAC, 32'h0040_0000, 32'h0040_0000, 32'h00C0_0000, "mac_3");
    issue(READ, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h00C0_0000, "mac_read");
    idle(5);

    // clk_en gating: one enabled cycle after issue, then five frozen cycles with a lost start.
    issue(MUL, 32'h0060_0000, 32'h0080_0000, 32'h00C0_0000, "gate_mul");
    idle(1);
    clk_en = 1'b0;
    idle(1);
    start = 1'b1;
    n     = MUL;
    dataa = 32'h0080_0000;
    datab = 32'h0080_0000;
    @(negedge clk);
    idle(3);
    clk_en = 1'b1;
    idle(6);

    // A done present when clk_en falls must hold through the frozen cycles.
    issue(MUL, 32'hFFC0_0000, 32'h0060_0000, 32'hFFA0_0000, "hold_mul");
    idle(2);
    clk_en = 1'b0;
    idle(2);
    checks++;
    assert (done === 1'b1 && result === 32'hFFA0_0000) else begin
      errors++;
      $error("FAIL done_hold: observed done=%b result=%h, required 1/ffa00000", done, result);
    end
    clk_en = 1'b1;
    idle(4);

    // Reset with two ops in flight: outputs clear at once and those ops never complete.
    issue(MUL, 32'h0060_0000, 32'h0080_0000, 32'h00C0_0000, "flush_a");
    issue(MAC, 32'h0040_0000, 32'h0040_0000, 32'h0100_0000, "flush_b");
    start = 1'b0;
    #2;
    aclr_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    assert (result === 32'h0000_0000 && done === 1'b0) else begin
      errors++;
      $error("FAIL async_reset: observed result=%h done=%b, required 00000000/0", result, done);
    end
    @(negedge clk);
    @(negedge clk);
    aclr_n = 1'b1;
    idle(6);
    issue(READ, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, "read_after_reset");
    idle(8);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL missing_done: observed %0d outstanding ops, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_add_pipe.md
# mul_add_pipe

Parametrised, fully pipelined fixed-point multiply / multiply-accumulate unit with a start/done handshake, the successor to the single-function `mul_add` block. It sits beside the CORDIC core as a custom-instruction-style arithmetic unit. It accepts one operation per enabled clock, supports four opcode-selected modes with an internal saturating accumulator, and returns a saturated WIDTH-bit result a fixed LAT cycles after issue.

## Interface
- WIDTH, 32: operand/result width, two's complement fixed point.
- FRAC, 22: fractional bits (default Q10.22); 1 ≤ FRAC < WIDTH.
- LAT, 3: pipeline latency in enabled cycles, start to done; ≥ 2.
- GUARD, 8: extra integer bits in the accumulator (accumulator width WIDTH+GUARD).
- clk  in  1  clock, rising edge.
- aclr_n  in  1  asynchronous active-low reset.
- clk_en  in  1  global enable; low freezes the whole block.
- start  in  1  issue strobe, sampled when clk_en=1.
- n  in  2  opcode: 0 MUL, 1 MAC, 2 CLR, 3 READ.
- dataa  in  WIDTH  operand A.
- datab  in  WIDTH  operand B.
- result  out  WIDTH  result, valid when done=1, held otherwise.
- done  out  1  one-cycle completion pulse per accepted start.

## Operation
- Accept: start=1 and clk_en=1 captures n, dataa, datab; no back-pressure, one issue per cycle.
- Product P = dataa*datab, full 2·WIDTH signed, scaled by >>FRAC (arithmetic) with rounding per Configuration.
- MUL: result = sat_W(P_scaled); accumulator unchanged.
- MAC: acc = sat_A(acc + P_scaled); result = sat_W(new acc).
- CLR: acc = 0; result = 0; operands ignored.
- READ: result = sat_W(acc); operands ignored.
- sat_W clamps to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; sat_A clamps to the WIDTH+GUARD range. Never wraps.
- Accumulator read/update happens only in the final stage, in issue order. Back-to-back MACs chain with no bubble, and READ/CLR observe every earlier-issued op.
- Per-stage valid bit travels with the op; done = final-stage valid.

## Timing
- Reset (aclr_n=0, async): result=0, done=0, acc=0, all stage valids cleared. In-flight ops are discarded and never produce done. Operation resumes on the first clock after release.
- Latency: start accepted in enabled cycle k → done=1 and result valid in enabled cycle k+LAT. Throughput is 1 op/cycle.
- done high for exactly one enabled cycle per op. Result holds its last value until the next done.
- clk_en=0: no register changes (pipeline, acc, result, done all hold), and start is ignored. A done that is high when clk_en falls stays high until the next enabled edge.
- start with clk_en=0 is lost, not queued.
- Opcode and operands are needed only in the accept cycle.

## Configuration
- MUL_ADD_PIPE_ROUND_EN defined: scaling adds 2^(FRAC−1) before the shift (round half up) and saturates on the rounding carry.
- Not defined: plain arithmetic shift (truncate toward −∞). Everything else is identical.

## Test plan
- Reset/idle: aclr_n low mid-stream with 2 ops in flight → result=0, done=0 immediately; no done after release; READ returns 0x00000000.
- MUL basic (defaults): 0x00600000 (1.5) × 0x00800000 (2.0) → done at +3 cycles, result 0x00C00000. 0xFFC00000 (−1.0) × 0x00600000 → 0xFFA00000.
- Saturation: MUL 0x40000000 (256.0) × 0x00800000 (2.0) → 0x7FFFFFFF. Negated operand → 0x80000000.
- MAC chain: CLR, then back-to-back MAC 1.0×1.0 three times, then READ → four consecutive dones (0, 0x00400000, 0x00800000, 0x00C00000), then READ = 0x00C00000.
- Rounding: MUL 0x00000001 × 0x00200000 → 0x00000001 with MUL_ADD_PIPE_ROUND_EN, 0x00000000 without. MUL 0xFFFFFFFF × 0x00200000 → 0x00000000 rounded, 0xFFFFFFFF truncated.
- clk_en gating: issue MUL, drop clk_en for 5 cycles after 1 cycle, pulse start while disabled → single done after 3 enabled cycles with the correct value, and no extra done.
